// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP32 field constants and divider state encoding shared by the FP datapath units
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] EXP_MASK   = 32'h7F80_0000;
    localparam logic [31:0] FRAC_MASK  = 32'h007F_FFFF;
    localparam logic [31:0] HIDDEN     = 32'h0080_0000;
    localparam logic [31:0] FP_INF_MAG = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fp_div_state_e;

endpackage

// File: rtl/fp_div_step.sv
// rtl/fp_div_step.sv - one combinational restoring-division step: (r, mb) -> (r_next, qbit)
module fp_div_step (
    input  logic [24:0] r,
    input  logic [23:0] mb,
    output logic [24:0] r_next,
    output logic        qbit
);

    logic [23:0] diff;

    assign qbit   = (r >= {1'b0, mb});
    // when r >= mb the difference is below mb, so 24 bits hold it exactly
    assign diff   = r[23:0] - mb;
    assign r_next = qbit ? {diff, 1'b0} : {r[23:0], 1'b0};

endmodule

// File: rtl/fp_div.sv
// rtl/fp_div.sv - multi-cycle FP32 restoring divider; FP_DIV_RNE_EN selects round-to-nearest-even
module fp_div
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic        dz,
    output logic        ovf
);

    localparam int CW = $clog2(QBITS);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DIV  = DIV;
    localparam logic [1:0] S_NORM = NORM;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]        state;
    logic              sign;
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [23:0]       mb;
    logic [24:0]       r;
    logic [QBITS-1:0]  q;
    logic [CW-1:0]     cnt;

    logic [24:0]       r_next;
    logic              qbit;

    logic signed [9:0] e_n;
    logic [FRAC_W-1:0] frac_n;
    logic [31:0]       res_n;
    logic              dz_n;
    logic              ovf_n;

`ifdef FP_DIV_RNE_EN
    logic [QBITS-2:0]  qn;
    logic              guard;
    logic              sticky;
    logic [23:0]       frac_sum;
`endif

    fp_div_step u_step (
        .r      (r),
        .mb     (mb),
        .r_next (r_next),
        .qbit   (qbit)
    );

    // q lies in (0.5, 2); a leading 0 means one extra bit is needed and the exponent drops by one
    always_comb begin
        e_n    = $signed({2'b00, ea}) - $signed({2'b00, eb})
               + (q[QBITS-1] ? 10'(BIAS) : 10'(BIAS - 1));
        frac_n = q[QBITS-1] ? q[QBITS-2:QBITS-24] : q[QBITS-3:QBITS-25];
`ifdef FP_DIV_RNE_EN
        qn       = q[QBITS-1] ? q[QBITS-2:0] : {q[QBITS-3:0], 1'b0};
        guard    = qn[QBITS-25];
        sticky   = (|qn[QBITS-26:0]) | (|r);
        frac_sum = {1'b0, qn[QBITS-2:QBITS-24]}
                 + 24'(guard & (sticky | qn[QBITS-24]));
        // carry out of the fraction means the mantissa rounded up to 2.0 -> 1.0 with exponent + 1
        frac_n   = frac_sum[22:0];
        if (frac_sum[23]) begin
            e_n = e_n + 10'sd1;
        end
`endif
        res_n = {sign, e_n[7:0], frac_n};
        dz_n  = 1'b0;
        ovf_n = 1'b0;
        if (eb == '0) begin
            res_n = {sign, FP_INF_MAG[30:0]};
            dz_n  = 1'b1;
        end else if (ea == '0) begin
            res_n = {sign, 31'b0};
        end else if (e_n >= 10'sd255) begin
            res_n = {sign, FP_INF_MAG[30:0]};
            ovf_n = 1'b1;
        end else if (e_n <= 10'sd0) begin
            res_n = {sign, 31'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            sign   <= 1'b0;
            ea     <= '0;
            eb     <= '0;
            mb     <= '0;
            r      <= '0;
            q      <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign  <= a[31] ^ b[31];
                        ea    <= a[FRAC_W+EXP_W-1:FRAC_W];
                        eb    <= b[FRAC_W+EXP_W-1:FRAC_W];
                        mb    <= {1'b1, b[FRAC_W-1:0]};
                        r     <= {2'b01, a[FRAC_W-1:0]};
                        q     <= '0;
                        cnt   <= CW'(QBITS - 1);
                        busy  <= 1'b1;
                        dz    <= 1'b0;
                        ovf   <= 1'b0;
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r <= r_next;
                    q <= {q[QBITS-2:0], qbit};
                    if (cnt == '0) begin
                        state <= S_NORM;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_NORM: begin
                    Result <= res_n;
                    dz     <= dz_n;
                    ovf    <= ovf_n;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - scoreboard bench for fp_div with directed FP32 vectors
module tb_fp_div;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        dz;
    logic        ovf;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    localparam int LAT = 27;

`ifdef FP_DIV_RNE_EN
    localparam logic [31:0] THIRD = 32'h3EAA_AAAB;
`else
    localparam logic [31:0] THIRD = 32'h3EAA_AAAA;
`endif

    fp_div #(.QBITS(26)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .dz     (dz),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // monitor: pops one expectation per done pulse
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", Result, e.res);
                    chk("dz", {31'b0, dz}, {31'b0, e.dz});
                    chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                    chk("latency", cyc, e.cyc);
                    chk("busy_at_done", {31'b0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] er, input logic ed, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res = er;
        e.dz  = ed;
        e.ovf = eo;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 120; i++) begin
            if (sb.size() == 0 && !busy && !done) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        exp_t e;
        int   busy_low;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_dz", {31'b0, dz}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 6/2 with busy watched every cycle up to done
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        busy_low = 0;
        for (int i = 0; i < LAT; i++) begin
            if (!busy) busy_low++;
            @(posedge clk);
            #1;
        end
        chk("busy_low_cycles", 32'(busy_low), 32'd0);
        drain();

        issue(32'h3F80_0000, 32'h4040_0000, THIRD, 1'b0, 1'b0);
        drain();
        issue(32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 1'b0);
        drain();
        issue(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0);
        drain();

        // start while busy is ignored; dz from the previous op clears
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        a = 32'h3F80_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1'b0, 1'b0);
        drain();
        issue(32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0);
        drain();
        issue(32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0, 1'b1);
        drain();
        issue(32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 1'b0);
        drain();

        // start held high: second acceptance two edges after done
        @(negedge clk);
        a = 32'h40C0_0000;
        b = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res = 32'h4040_0000;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        e.cyc = cyc + 2 * LAT + 2;
        sb.push_back(e);
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset mid-operation aborts with no done
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", Result, 32'd0);
        chk("abort_dz", {31'b0, dz}, 32'd0);
        chk("abort_ovf", {31'b0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (35) @(negedge clk);
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
